// File: rtl/v_requant_relu_pkg.sv
// Shared types and constants for the vector requantise/ReLU block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, signed saturation limits as functions of output width.
package v_requant_relu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Largest value representable in an nbits-wide two's complement word.
    function automatic int sat_max(input int nbits);
        return (2 ** (nbits - 1)) - 1;
    endfunction

    // Smallest value representable in an nbits-wide two's complement word.
    function automatic int sat_min(input int nbits);
        return -(2 ** (nbits - 1));
    endfunction

endpackage

// File: rtl/v_requant_lane.sv
// One element of requantisation: round-half-up, arithmetic shift right, saturate, optional ReLU.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of in_val.
// Ports: in_val (signed InBits accumulator) -> out_val (signed NBits result).
// Optional feature: define VREQ_RELU_EN to clamp negative saturated results to zero.
module v_requant_lane
    import v_requant_relu_pkg::*;
#(
    parameter int InBits = 16,
    parameter int NBits  = 8,
    parameter int Shift  = 4
) (
    input  logic signed [InBits-1:0] in_val,
    output logic signed [NBits-1:0]  out_val
);

    // Half an output LSB; the double shift yields 0 when Shift is 0 without a negative shift count.
    localparam logic [InBits:0] RndAdd = ((InBits + 1)'(1) << Shift) >> 1;
    localparam logic signed [InBits:0] MaxV = (InBits + 1)'(sat_max(NBits));
    localparam logic signed [InBits:0] MinV = (InBits + 1)'(sat_min(NBits));

    // One guard bit so that rounding the most positive input cannot wrap.
    logic signed [InBits:0] ext_val;
    logic signed [InBits:0] rnd_val;
    logic signed [InBits:0] shf_val;
    logic signed [NBits-1:0] sat_val;

    assign ext_val = {in_val[InBits-1], in_val};
    assign rnd_val = ext_val + $signed(RndAdd);
    assign shf_val = rnd_val >>> Shift;

    always_comb begin
        sat_val = shf_val[NBits-1:0];
        if (shf_val > MaxV) begin
            sat_val = MaxV[NBits-1:0];
        end else if (shf_val < MinV) begin
            sat_val = MinV[NBits-1:0];
        end
    end

`ifdef VREQ_RELU_EN
    assign out_val = sat_val[NBits-1] ? '0 : sat_val;
`else
    assign out_val = sat_val;
`endif

endmodule

// File: rtl/v_requant_relu.sv
// Reads a vector chunk-by-chunk from an upstream FIFO, requantises each element and writes chunks downstream.
// Latency: write strobe 2 cycles after each read strobe; vector-done pulse 6 cycles after start at defaults.
// Backpressure: none downstream; upstream paced only by in_data_ready (complete vector present).
// Ports: clk_in, rst_in (async active-low); in_data_ready/in_data from upstream, req_chunk_in read strobe;
//        write_out_data/req_chunk_out to downstream; out_vector_valid one-cycle end-of-vector pulse.
// Optional feature: VREQ_RELU_EN (see v_requant_lane).
module v_requant_relu
    import v_requant_relu_pkg::*;
#(
    parameter int InVecLength = 6,
    parameter int WorkingRegs = 2,
    parameter int InBits      = 16,
    parameter int NBits       = 8,
    parameter int Shift       = 4
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  in_data_ready,
    input  logic [WorkingRegs-1:0][InBits-1:0]    in_data,
    output logic                                  req_chunk_in,
    output logic [WorkingRegs-1:0][NBits-1:0]     write_out_data,
    output logic                                  req_chunk_out,
    output logic                                  out_vector_valid
);

    localparam int NumChunks = InVecLength / WorkingRegs;
    localparam int CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam logic [CntW-1:0] LastChunk = CntW'(NumChunks - 1);

    if ((InVecLength % WorkingRegs) != 0) begin : g_bad_cfg
        $error("InVecLength must be a multiple of WorkingRegs");
    end

    state_t              state;
    state_t              state_nxt;
    logic [CntW-1:0]     chunk_cnt;
    logic                drain_cnt;
    logic                rd_vld;
    logic [WorkingRegs-1:0][NBits-1:0] lane_out;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        req_chunk_in     = 1'b0;
        out_vector_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_data_ready) state_nxt = ST_READ;
            end
            ST_READ: begin
                req_chunk_in = 1'b1;
                if (chunk_cnt == LastChunk) state_nxt = ST_DRAIN;
            end
            // Two cycles cover the read-data and result-register stages of the last chunk.
            ST_DRAIN: begin
                if (drain_cnt) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_vector_valid = 1'b1;
                state_nxt = in_data_ready ? ST_READ : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            chunk_cnt <= '0;
            drain_cnt <= 1'b0;
        end else begin
            if (state == ST_READ) begin
                chunk_cnt <= (chunk_cnt == LastChunk) ? '0 : chunk_cnt + 1'b1;
            end
            drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // ---------------- datapath ----------------
    for (genvar i = 0; i < WorkingRegs; i++) begin : g_lane
        v_requant_lane #(
            .InBits (InBits),
            .NBits  (NBits),
            .Shift  (Shift)
        ) u_lane (
            .in_val  (in_data[i]),
            .out_val (lane_out[i])
        );
    end

    // rd_vld marks the cycle the upstream chunk is on in_data; the lanes are
    // combinational, so the result register sits directly behind it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_vld         <= 1'b0;
            req_chunk_out  <= 1'b0;
            write_out_data <= '0;
        end else begin
            rd_vld        <= req_chunk_in;
            req_chunk_out <= rd_vld;
            if (rd_vld) begin
                write_out_data <= lane_out;
            end
        end
    end

endmodule

// File: tb/tb_v_requant_relu.sv
// Directed bench for v_requant_relu at default parameters: strobe timing, rounding, saturation,
// back-to-back vectors and mid-vector reset. Define VREQ_RELU_EN for both bench and RTL to check ReLU.
// Upstream FIFO is modelled as a queue answering each read strobe one cycle later.
module tb_v_requant_relu;

    logic              clk_in;
    logic              rst_in;
    logic              in_data_ready;
    logic [1:0][15:0]  in_data;
    logic              req_chunk_in;
    logic [1:0][7:0]   write_out_data;
    logic              req_chunk_out;
    logic              out_vector_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] fifo_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] last_out;
    logic        fifo_rd;

    logic [15:0] vin  [0:11];
    logic [7:0]  vexp [0:11];

    v_requant_relu u_dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .in_data_ready    (in_data_ready),
        .in_data          (in_data),
        .req_chunk_in     (req_chunk_in),
        .write_out_data   (write_out_data),
        .req_chunk_out    (req_chunk_out),
        .out_vector_valid (out_vector_valid)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Upstream FIFO: data for a strobe seen in cycle n appears just after the edge starting cycle n+1.
    initial begin
        fifo_rd = 1'b0;
        forever begin
            @(negedge clk_in);
            fifo_rd = req_chunk_in;
            @(posedge clk_in);
            #1;
            if (fifo_rd) begin
                if (fifo_q.size() > 0) in_data = fifo_q.pop_front();
                else                   in_data = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Vector v (0 = A, 1 = B): element 2k goes to in_data[0], 2k+1 to in_data[1].
    task automatic load_vector(input int v);
        for (int k = 0; k < 3; k++) begin
            fifo_q.push_back({vin[v*6 + 2*k + 1], vin[v*6 + 2*k]});
            exp_q.push_back({vexp[v*6 + 2*k + 1], vexp[v*6 + 2*k]});
        end
    endtask

    task automatic cycle_check(input string name, input int c, input logic e_rin,
                               input logic e_rout, input logic e_ovv);
        logic [15:0] e_dat;
        check($sformatf("%s c%0d req_chunk_in", name, c), 32'(req_chunk_in), 32'(e_rin));
        check($sformatf("%s c%0d req_chunk_out", name, c), 32'(req_chunk_out), 32'(e_rout));
        check($sformatf("%s c%0d out_vector_valid", name, c), 32'(out_vector_valid), 32'(e_ovv));
        if (e_rout) begin
            if (exp_q.size() > 0) e_dat = exp_q.pop_front();
            else                  e_dat = 16'hxxxx;
            last_out = e_dat;
            check($sformatf("%s c%0d data", name, c), 32'(write_out_data), 32'(e_dat));
        end else begin
            check($sformatf("%s c%0d data hold", name, c), 32'(write_out_data), 32'(last_out));
        end
    endtask

    // Vector j starts at cycle 6j: reads at 6j+1..6j+3, writes at 6j+3..6j+5, done at 6j+6.
    task automatic run_window(input string name, input int ncyc, input int ready_cycles, input int nvec);
        logic e_rin, e_rout, e_ovv;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk_in);
            #1;
            in_data_ready = (c < ready_cycles);
            @(negedge clk_in);
            e_rin  = (c >= 1) && (((c - 1) % 6) < 3) && (((c - 1) / 6) < nvec);
            e_rout = (c >= 3) && (((c - 3) % 6) < 3) && (((c - 3) / 6) < nvec);
            e_ovv  = (c >= 6) && ((c % 6) == 0) && ((c / 6) <= nvec);
            cycle_check(name, c, e_rin, e_rout, e_ovv);
        end
        check({name, " leftover"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Vector A: rounding and saturation corners.
        vin[0] = 16'h0038; vexp[0] = 8'h04;
        vin[1] = 16'hFFE8;
        vin[2] = 16'h7FFF; vexp[2] = 8'h7F;
        vin[3] = 16'h8000;
        vin[4] = 16'h0007; vexp[4] = 8'h00;
        vin[5] = 16'h0008; vexp[5] = 8'h01;
        // Vector B: values around the output range edges.
        vin[6]  = 16'hFFF8; vexp[6]  = 8'h00;
        vin[7]  = 16'h07F0; vexp[7]  = 8'h7F;
        vin[8]  = 16'h0800; vexp[8]  = 8'h7F;
        vin[9]  = 16'hF800;
        vin[10] = 16'hF7F0;
        vin[11] = 16'h0123; vexp[11] = 8'h12;
`ifdef VREQ_RELU_EN
        vexp[1] = 8'h00; vexp[3] = 8'h00; vexp[9] = 8'h00; vexp[10] = 8'h00;
`else
        vexp[1] = 8'hFF; vexp[3] = 8'h80; vexp[9] = 8'h80; vexp[10] = 8'h80;
`endif

        rst_in        = 1'b0;
        in_data_ready = 1'b0;
        in_data       = '0;
        last_out      = '0;
        #2;
        check("reset req_chunk_in", 32'(req_chunk_in), 32'd0);
        check("reset req_chunk_out", 32'(req_chunk_out), 32'd0);
        check("reset out_vector_valid", 32'(out_vector_valid), 32'd0);
        check("reset data", 32'(write_out_data), 32'd0);
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);

        load_vector(0);
        run_window("single_a", 9, 1, 1);
        load_vector(1);
        run_window("single_b", 9, 1, 1);
        load_vector(0);
        load_vector(1);
        run_window("stream", 15, 12, 2);

        // Mid-vector reset: start a vector, assert reset in cycle 2.
        load_vector(1);
        @(posedge clk_in); #1; in_data_ready = 1'b1;
        @(negedge clk_in); cycle_check("rst", 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk_in); #1; in_data_ready = 1'b0;
        @(negedge clk_in); cycle_check("rst", 1, 1'b1, 1'b0, 1'b0);
        @(posedge clk_in); #1; rst_in = 1'b0;
        #1;
        check("midrst req_chunk_in", 32'(req_chunk_in), 32'd0);
        check("midrst req_chunk_out", 32'(req_chunk_out), 32'd0);
        check("midrst out_vector_valid", 32'(out_vector_valid), 32'd0);
        check("midrst data", 32'(write_out_data), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        last_out = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            cycle_check("in_rst", c, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk_in); #1; rst_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_in);
            cycle_check("post_rst_idle", c, 1'b0, 1'b0, 1'b0);
        end

        load_vector(0);
        run_window("after_rst", 9, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/v_requant_relu.md
V_REQUANT_RELU -- requirements
Module: v_requant_relu

Interface
REQ-001 Parameter InVecLength, default 6: elements per vector; SHALL be an integer multiple of WorkingRegs.
REQ-002 Parameter WorkingRegs, default 2: elements per chunk, i.e. per read and per write.
REQ-003 Parameter InBits, default 16: signed accumulator element width from the upstream MAC FIFO.
REQ-004 Parameter NBits, default 8: signed output element width.
REQ-005 Parameter Shift, default 4: right-shift amount for requantisation, range 0..InBits-1.
REQ-006 clk_in  input  1: single clock, rising edge.
REQ-007 rst_in  input  1: reset, asynchronous, active-low.
REQ-008 in_data_ready  input  1: upstream FIFO holds a complete vector.
REQ-009 in_data  input  [WorkingRegs][InBits]: chunk from the upstream FIFO, valid 1 cycle after req_chunk_in.
REQ-010 req_chunk_in  output  1: read strobe to the upstream FIFO.
REQ-011 write_out_data  output  [WorkingRegs][NBits]: requantised chunk.
REQ-012 req_chunk_out  output  1: write strobe to the downstream FIFO, qualifying write_out_data.
REQ-013 out_vector_valid  output  1: one-cycle pulse when a full vector has been written.

Function
REQ-014 NumChunks = InVecLength/WorkingRegs; the chunk counter SHALL count 0..NumChunks-1 and wrap to 0 at vector end.
REQ-015 FSM states: IDLE, READ, DRAIN, DONE.
REQ-016 IDLE->READ when in_data_ready=1; DONE->READ when in_data_ready=1, else DONE->IDLE.
REQ-017 READ SHALL assert req_chunk_in on NumChunks consecutive cycles, then go to DRAIN.
REQ-018 DRAIN SHALL last 2 cycles while in-flight chunks complete, then go to DONE.
REQ-019 DONE SHALL last 1 cycle and assert out_vector_valid for that cycle only.
REQ-020 in_data_ready SHALL be ignored in READ and DRAIN; there is no downstream backpressure.
REQ-021 Pipeline: in_data is captured 1 cycle after its strobe; the result is registered; req_chunk_out and write_out_data are asserted exactly 2 cycles after the matching req_chunk_in.
REQ-022 Chunk order and element order within a chunk SHALL be preserved.
REQ-023 Per element: if Shift>0, add 2^(Shift-1); then arithmetic shift right by Shift, computed in InBits+1 bits so the rounding add cannot overflow.
REQ-024 The shifted result SHALL saturate to [-2^(NBits-1), 2^(NBits-1)-1].
REQ-025 When req_chunk_out=0, write_out_data SHALL hold its last value.

Reset
REQ-026 rst_in low SHALL force, immediately: state IDLE, counters 0, pipeline valids 0, req_chunk_in=0, req_chunk_out=0, out_vector_valid=0, write_out_data=0.
REQ-027 Reset mid-vector SHALL discard the partial vector, with no out_vector_valid pulse; the first vector after release processes normally.

Configuration
REQ-028 With VREQ_RELU_EN defined, every saturated negative result SHALL be replaced by 0 before registering; timing is unchanged.
REQ-029 Without VREQ_RELU_EN, signed saturated values pass unmodified.

Structure
REQ-030 The shared package SHALL hold the FSM state enum typedef and the saturation-limit constant functions of NBits.
REQ-031 One sub-module, v_requant_lane, SHALL implement the per-element round/shift/saturate/ReLU logic (combinational) and be instantiated WorkingRegs times.

Verification (defaults; cycle 0 = first in_data_ready high in IDLE)
REQ-032 Timing: in_data_ready pulse at cycle 0 -> req_chunk_in at cycles 1-3, req_chunk_out at cycles 3-5, out_vector_valid at cycle 6 only.
REQ-033 Rounding:
- in 0x0038 (56) -> 0x04.
- in 0xFFE8 (-24) -> 0xFF without VREQ_RELU_EN, 0x00 with it.
REQ-034 Saturation:
- in 0x7FFF -> 0x7F.
- in 0x8000 -> 0x80 without VREQ_RELU_EN, 0x00 with it.
REQ-035 in_data_ready held high -> out_vector_valid pulses every 6 cycles (cycles 6, 12, ...), with no missing or duplicated req_chunk_out.
REQ-036 rst_in low at cycle 2 -> all outputs 0 at once and no out_vector_valid; release, then in_data_ready -> normal REQ-032 timing from that point.
